// File: rtl/bcd_conv_arbiter_if.sv
// rtl/bcd_conv_arbiter_if.sv - start/done handshake between the arbiter and the shared binary-to-BCD converter
interface bcd_conv_arbiter_if #(
  parameter int BIN_W = 16,
  parameter int BCD_W = 16
);
  logic             conv_start;
  logic [BIN_W-1:0] conv_bin;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  modport master (
    output conv_start,
    output conv_bin,
    input  conv_done,
    input  conv_bcd
  );

  modport slave (
    input  conv_start,
    input  conv_bin,
    output conv_done,
    output conv_bcd
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - round-robin sharing of one binary-to-BCD converter among N_REQ channels
// Updates coalesce in per-channel hold registers; each grant runs one start/done exchange.
module bcd_conv_arbiter #(
  parameter int N_REQ   = 3,
  parameter int BIN_W   = 16,
  parameter int BCD_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         upd,
  input  logic [N_REQ*BIN_W-1:0]   upd_bin,
  bcd_conv_arbiter_if.master       conv,
  output logic [N_REQ*BCD_W-1:0]   bcd_out,
  output logic [N_REQ-1:0]         bcd_valid,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [BIN_W-1:0] hold [N_REQ];
  logic [N_REQ-1:0] pending;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] grant_ch;
  logic [PTR_W-1:0] idx;
  logic             grant_any;
  logic [TMR_W-1:0] timer;
  logic [BIN_W-1:0] conv_bin_q;
  logic             tmo_hit;

  // Scan from farthest to nearest so the nearest pending channel after ptr is the last one kept.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (pending[idx]) begin
        grant_any = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  assign tmo_hit = (state == WAIT) && !conv.conv_done && (timer == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (conv.conv_done || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  assign conv.conv_start = (state == START);
  assign conv.conv_bin   = conv_bin_q;
  assign busy            = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      ptr         <= PTR_W'(N_REQ - 1);
      sel         <= '0;
      timer       <= '0;
      conv_bin_q  <= '0;
      bcd_out     <= '0;
      bcd_valid   <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < N_REQ; i++) hold[i] <= '0;
    end else begin
      bcd_valid   <= '0;
      timeout_err <= 1'b0;

      if (state == IDLE && grant_any) begin
        sel              <= grant_ch;
        ptr              <= grant_ch;
        conv_bin_q       <= hold[grant_ch];
        pending[grant_ch] <= 1'b0;
      end

      if (state == START)     timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;

      if (state == WAIT && conv.conv_done) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (i == int'(sel)) begin
            bcd_out[i*BCD_W +: BCD_W] <= conv.conv_bcd;
            bcd_valid[i]              <= 1'b1;
          end
        end
      end

      if (tmo_hit) begin
        timeout_err  <= 1'b1;
        pending[sel] <= 1'b1;
      end

      // Fresh updates come last so they override a same-cycle grant clear.
      for (int i = 0; i < N_REQ; i++) begin
        if (upd[i]) begin
          hold[i]    <= upd_bin[i*BIN_W +: BIN_W];
          pending[i] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - scoreboard bench for bcd_conv_arbiter with a latency-programmable converter model
module tb_bcd_conv_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  upd = '0;
  logic [47:0] upd_bin = '0;
  logic [47:0] bcd_out;
  logic [2:0]  bcd_valid;
  logic        busy;
  logic        timeout_err;

  logic        model_done = 1'b0;
  logic        stray_done = 1'b0;
  logic [15:0] model_bcd  = '0;
  logic        model_en   = 1'b1;
  int          lat        = 20;

  typedef struct {
    int          ch;
    logic [15:0] bcd;
  } res_t;

  logic [15:0] exp_conv [$];
  res_t        exp_res  [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_start = 0, n_valid = 0, n_tmo = 0;
  int last_start_cyc = -1, last_valid_cyc = -1, last_tmo_cyc = -1;

  bcd_conv_arbiter_if #(.BIN_W(16), .BCD_W(16)) cif ();

  assign cif.conv_done = model_done | stray_done;
  assign cif.conv_bcd  = model_bcd;

  bcd_conv_arbiter #(.N_REQ(3), .BIN_W(16), .BCD_W(16), .TIMEOUT(64)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .upd         (upd),
    .upd_bin     (upd_bin),
    .conv        (cif),
    .bcd_out     (bcd_out),
    .bcd_valid   (bcd_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input logic [15:0] b);
    int v;
    v = int'(b);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Converter model: done pulse lat cycles after the start cycle.
  initial begin : conv_model
    logic [15:0] b;
    forever begin
      @(negedge clk);
      if (rst && cif.conv_start && model_en) begin
        b = cif.conv_bin;
        repeat (lat) @(posedge clk);
        #1;
        model_done = 1'b1;
        model_bcd  = to_bcd(b);
        @(posedge clk);
        #1;
        model_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    res_t        r;
    if (rst) begin
      if (cif.conv_start) begin
        n_start++;
        last_start_cyc = cyc;
        if (exp_conv.size() == 0) check("conv_start_unexpected", 1, 0);
        else begin
          e = exp_conv.pop_front();
          check("conv_bin", cif.conv_bin, e);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (bcd_valid[i]) begin
          n_valid++;
          last_valid_cyc = cyc;
          if (exp_res.size() == 0) check("bcd_valid_unexpected", 1, 0);
          else begin
            r = exp_res.pop_front();
            check("valid_channel", i, r.ch);
            check("bcd_out_slice", bcd_out[i*16 +: 16], r.bcd);
          end
        end
      end
      if (timeout_err) begin
        n_tmo++;
        last_tmo_cyc = cyc;
      end
      if (timeout_err || bcd_valid != 0) check("valid_tmo_exclusive", timeout_err && (bcd_valid != 0), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input logic [2:0] m, input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2);
    upd     = m;
    upd_bin = {v2, v1, v0};
    tick();
    upd     = '0;
  endtask

  task automatic push_res(input int ch, input logic [15:0] b);
    res_t r;
    r.ch  = ch;
    r.bcd = b;
    exp_res.push_back(r);
  endtask

  task automatic wait_valid(input int target, input int budget, input string name);
    int k = 0;
    while (n_valid < target && k < budget) begin
      tick();
      k++;
    end
    check(name, n_valid, target);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_conv_start"}, cif.conv_start, 0);
    check({tag, "_conv_bin"}, cif.conv_bin, 0);
    check({tag, "_bcd_out"}, bcd_out, 0);
    check({tag, "_bcd_valid"}, bcd_valid, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int c0, s0, v0, t0, k;

    repeat (3) tick();
    check_cleared("reset");
    rst = 1'b1;
    tick();

    // Single update, latency 20
    lat = 20;
    exp_conv.push_back(16'd1000);
    push_res(0, 16'h1000);
    c0 = cyc;
    post(3'b001, 16'd1000, 16'd0, 16'd0);
    wait_valid(1, 60, "t1_valid_count");
    check("t1_start_cycle", last_start_cyc, c0 + 2);
    check("t1_valid_cycle", last_valid_cyc, c0 + 23);
    check("t1_other_slices", bcd_out[47:16], 0);

    // Simultaneous updates from reset pointer
    do_reset();
    lat = 3;
    s0 = n_start;
    v0 = n_valid;
    exp_conv.push_back(16'd999);
    exp_conv.push_back(16'd25);
    exp_conv.push_back(16'd1);
    push_res(0, 16'h0999);
    push_res(1, 16'h0025);
    push_res(2, 16'h0001);
    post(3'b111, 16'd999, 16'd25, 16'd1);
    wait_valid(v0 + 3, 80, "t2_valid_count");
    repeat (10) tick();
    check("t2_start_count", n_start - s0, 3);

    // Coalescing on channel 1 while channel 0 converts
    lat = 10;
    s0 = n_start;
    v0 = n_valid;
    exp_conv.push_back(16'd10);
    exp_conv.push_back(16'd7);
    push_res(0, 16'h0010);
    push_res(1, 16'h0007);
    post(3'b001, 16'd10, 16'd0, 16'd0);
    tick();
    post(3'b010, 16'd0, 16'd5, 16'd0);
    tick();
    post(3'b010, 16'd0, 16'd7, 16'd0);
    wait_valid(v0 + 2, 80, "t3_valid_count");
    repeat (5) tick();
    check("t3_start_count", n_start - s0, 2);

    // Round-robin with channels 0/2 continuously pending, channel 1 raised mid-stream
    do_reset();
    lat = 2;
    s0 = n_start;
    v0 = n_valid;
    exp_conv.push_back(16'd11); push_res(0, 16'h0011);
    exp_conv.push_back(16'd22); push_res(2, 16'h0022);
    exp_conv.push_back(16'd11); push_res(0, 16'h0011);
    exp_conv.push_back(16'd33); push_res(1, 16'h0033);
    exp_conv.push_back(16'd22); push_res(2, 16'h0022);
    exp_conv.push_back(16'd11); push_res(0, 16'h0011);
    for (k = 0; k < 13; k++) begin
      upd     = (k == 10) ? 3'b111 : 3'b101;
      upd_bin = {16'd22, 16'd33, 16'd11};
      tick();
    end
    upd = '0;
    wait_valid(v0 + 6, 120, "t4_valid_count");
    repeat (5) tick();
    check("t4_start_count", n_start - s0, 6);

    // Timeout with a silent converter, then retry succeeds
    model_en = 1'b0;
    t0 = n_tmo;
    v0 = n_valid;
    exp_conv.push_back(16'd44);
    exp_conv.push_back(16'd44);
    push_res(1, 16'h0044);
    c0 = cyc;
    post(3'b010, 16'd0, 16'd44, 16'd0);
    k = 0;
    while (n_tmo == t0 && k < 100) begin
      tick();
      k++;
    end
    model_en = 1'b1;
    lat = 5;
    check("t5_timeout_count", n_tmo - t0, 1);
    check("t5_timeout_cycle", last_tmo_cyc, c0 + 67);
    check("t5_bcd_kept", bcd_out[31:16], 16'h0033);
    wait_valid(v0 + 1, 60, "t5_retry_valid");
    repeat (3) tick();
    v0 = n_valid;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    repeat (3) tick();
    check("t5_stray_done_ignored", n_valid, v0);
    check("t5_single_timeout", n_tmo - t0, 1);

    // Reset in the middle of a conversion
    lat = 20;
    exp_conv.push_back(16'd55);
    post(3'b001, 16'd55, 16'd0, 16'd0);
    repeat (8) tick();
    check("t6_busy_before", busy, 1);
    rst = 1'b0;
    #3;
    check_cleared("t6_in_reset");
    tick();
    rst = 1'b1;
    v0 = n_valid;
    repeat (30) tick();
    check("t6_late_done_ignored", n_valid, v0);
    check("t6_bcd0_zero", bcd_out[15:0], 0);
    check("t6_idle", busy, 0);

    check("exp_conv_drained", exp_conv.size(), 0);
    check("exp_res_drained", exp_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
